// File: rtl/cmp_window_counter.sv
// Comparator bitstream window counter: synchronizes the comparator decision and counts
// ones over 2^WIN_LOG2 qualified samples, handing each window's count out on valid/ready.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | not accumulating; accumulator, sample counter, strobe pipe held at 0
// S_ACCUM | counting qualified samples, windows back-to-back
module cmp_window_counter #(
    parameter int WIN_LOG2 = 6,
    parameter int CNT_W    = WIN_LOG2 + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmp_out,
    input  logic             i_sample,
    input  logic             i_zero,
    input  logic             i_enable,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_result,
    output logic             o_valid,
    output logic             o_overrun,
    output logic             o_busy
);

    generate
        if (WIN_LOG2 < 1 || WIN_LOG2 > 10) begin : g_bad_win
            $error("cmp_window_counter: WIN_LOG2 must be 1..10");
        end
        if (CNT_W < WIN_LOG2 + 1) begin : g_bad_cnt
            $error("cmp_window_counter: CNT_W too narrow for a full window");
        end
    endgenerate

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    localparam logic [WIN_LOG2-1:0] SCNT_LAST = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_cmp_s1;
    logic                r_cmp_s2;
    logic                r_smp_d1;
    logic                r_smp_d2;
    logic [CNT_W-1:0]    r_acc;
    logic [WIN_LOG2-1:0] r_scnt;
    logic [CNT_W-1:0]    r_result;
    logic                r_valid;
    logic                r_overrun;

    logic                w_accum;
    logic                w_abort;
    logic                w_qual;
    logic                w_done;
    logic [CNT_W-1:0]    w_sum;

    assign w_accum = (r_state == S_ACCUM);
    assign w_abort = w_accum & (~i_enable | i_zero);
    // zero suppresses a strobe arriving in the same cycle
    assign w_qual  = r_smp_d2 & w_accum & ~i_zero;
    assign w_done  = w_qual & (r_scnt == SCNT_LAST);
    assign w_sum   = r_acc + {{(CNT_W-1){1'b0}}, r_cmp_s2};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_enable & ~i_zero) w_state_nxt = S_ACCUM;
            S_ACCUM: if (~i_enable | i_zero) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = w_accum;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cmp_s1 <= 1'b0;
            r_cmp_s2 <= 1'b0;
            r_smp_d1 <= 1'b0;
            r_smp_d2 <= 1'b0;
        end else begin
            r_cmp_s1 <= i_cmp_out;
            r_cmp_s2 <= r_cmp_s1;
            if (w_accum) begin
                r_smp_d1 <= i_sample;
                r_smp_d2 <= r_smp_d1;
            end else begin
                r_smp_d1 <= 1'b0;
                r_smp_d2 <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc  <= '0;
            r_scnt <= '0;
        end else if (~w_accum || w_abort || w_done) begin
            r_acc  <= '0;
            r_scnt <= '0;
        end else if (w_qual) begin
            r_acc  <= w_sum;
            r_scnt <= r_scnt + WIN_LOG2'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_done) begin
                r_result <= w_sum;
                r_valid  <= 1'b1;
            end else if (r_valid & i_ready) begin
                r_valid <= 1'b0;
            end
            // a handshake in the completing cycle consumes the old word, so no overrun
            if (~i_enable) begin
                r_overrun <= 1'b0;
            end else if (w_done & r_valid & ~i_ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_result  = r_result;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_cmp_window_counter.sv
// Directed bench for cmp_window_counter with WIN_LOG2=3; consumed words are checked
// against a queue of expected window counts, state/timing points are checked inline.
module tb_cmp_window_counter;

    localparam int WIN_LOG2 = 3;
    localparam int CNT_W    = WIN_LOG2 + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmp_out;
    logic             sample;
    logic             zero;
    logic             enable;
    logic             ready;
    logic [CNT_W-1:0] result;
    logic             valid;
    logic             overrun;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    cmp_window_counter #(.WIN_LOG2(WIN_LOG2), .CNT_W(CNT_W)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_cmp_out (cmp_out),
        .i_sample  (sample),
        .i_zero    (zero),
        .i_enable  (enable),
        .i_ready   (ready),
        .o_result  (result),
        .o_valid   (valid),
        .o_overrun (overrun),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic b);
        sample  = 1'b1;
        cmp_out = b;
        tick();
        sample  = 1'b0;
    endtask

    // One full window of strobes from an 8-bit pattern (LSB first); optionally queue its count.
    task automatic window(input logic [7:0] bits, input bit push);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            strobe(bits[i]);
            ones += int'(bits[i]);
        end
        if (push) exp_q.push_back(ones);
    endtask

    // Consumer side: a word is taken at the edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", int'(result), -1);
            end else begin
                check("consumed_word", int'(result), exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        cmp_out = 1'b0;
        sample  = 1'b0;
        zero    = 1'b0;
        enable  = 1'b0;
        ready   = 1'b1;
        ticks(2);
        reset = 1'b0;
        tick();
        check("rst_result", int'(result), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);

        enable = 1'b1;
        tick();
        check("busy_rise", int'(busy), 1);

        // all-ones window, valid visible 3 cycles after the 8th strobe
        window(8'hFF, 1);
        tick();
        check("lat_valid_k1", int'(valid), 0);
        tick();
        check("lat_valid_k2", int'(valid), 1);
        check("lat_result", int'(result), 8);
        tick();
        check("valid_pulse_end", int'(valid), 0);

        // back-to-back windows across the counter wrap
        window(8'b0101_0101, 1);
        window(8'h00, 1);
        ticks(4);

        // zero aborts a partial window
        for (int i = 0; i < 5; i++) strobe(1'b1);
        zero = 1'b1;
        tick();
        check("abort_busy", int'(busy), 0);
        tick();
        zero = 1'b0;
        tick();
        check("rearm_busy", int'(busy), 1);
        window(8'hFF, 1);
        ticks(4);
        check("abort_no_extra", int'(valid), 0);

        // overrun: two windows with nobody consuming
        ready = 1'b0;
        window(8'b0000_0111, 0);
        window(8'b0011_1111, 1);
        ticks(4);
        check("ovr_valid", int'(valid), 1);
        check("ovr_result", int'(result), 6);
        check("ovr_flag", int'(overrun), 1);
        enable = 1'b0;
        tick();
        check("ovr_clear", int'(overrun), 0);
        check("ovr_valid_held", int'(valid), 1);
        check("ovr_busy_fall", int'(busy), 0);
        tick();
        check("ovr_valid_held2", int'(valid), 1);
        ready = 1'b1;
        tick();
        check("ovr_drained", int'(valid), 0);

        // ready arrives exactly as the next window completes
        ready  = 1'b0;
        enable = 1'b1;
        tick();
        window(8'b0000_0011, 1);
        ticks(3);
        check("pend_valid", int'(valid), 1);
        window(8'b0001_1111, 1);
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("coinc_valid", int'(valid), 1);
        check("coinc_result", int'(result), 5);
        check("coinc_overrun", int'(overrun), 0);
        ready = 1'b1;
        tick();
        check("coinc_drained", int'(valid), 0);

        // reset mid-window while a word is pending
        ready = 1'b0;
        window(8'b0000_1111, 0);
        ticks(3);
        check("pre_rst_valid", int'(valid), 1);
        for (int i = 0; i < 3; i++) strobe(1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_result", int'(result), 0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_busy", int'(busy), 0);
        ready = 1'b1;
        tick();
        window(8'b1000_0001, 1);
        ticks(4);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
